// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the sequential multiply/divide unit.
//   OP_MUL / OP_DIV  - values of the op input
//   SIGN_SIGNED      - sign input value selecting two's-complement operands
//   state_e          - controller states IDLE / RUN / FIX
//   LATENCY          - start-to-done latency for the default operand width
// Optional feature macro: SEQ_MULDIV_EARLY_OUT_EN (consumed by seq_muldiv).
package muldiv_pkg;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam logic [1:0] SIGN_SIGNED = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_e;

    localparam int unsigned WIDTH_DEFAULT = 32;
    localparam int unsigned LATENCY       = WIDTH_DEFAULT + 2;

endpackage

// File: rtl/muldiv_negate.sv
// muldiv_negate: conditional two's-complement negation.
//   en_i   - negate when high, pass through when low
//   val_i  - WIDTH-bit operand
//   val_o  - en_i ? -val_i : val_i
// Used both to take magnitudes on entry and to restore result signs.
module muldiv_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             en_i,
    input  logic [WIDTH-1:0] val_i,
    output logic [WIDTH-1:0] val_o
);

    always_comb begin
        val_o = en_i ? (~val_i + WIDTH'(1)) : val_i;
    end

endmodule

// File: rtl/seq_muldiv.sv
// seq_muldiv: multi-cycle multiply/divide unit, one bit per clock, HI/LO results.
//   clk, reset         - rising-edge clock, synchronous active-high reset
//   start, op, sign    - request strobe (taken only when idle), 0=mul/1=div, 2'b01=signed
//   A, B               - multiplicand/dividend, multiplier/divisor
//   busy, done         - busy while an operation is in flight, one-cycle done pulse
//   outHI, outLO       - product high/low or remainder/quotient, held until next completion
//   dbz                - divide-by-zero flag of the last completed operation
// Optional feature: define SEQ_MULDIV_EARLY_OUT_EN to skip the iterations when B==0.
module seq_muldiv
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [1:0]       sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] outHI,
    output logic [WIDTH-1:0] outLO,
    output logic             dbz
);

    localparam int unsigned CntW = $clog2(WIDTH);

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                op_q, op_d;
    logic                neg_a_q, neg_a_d;     // dividend was negative (remainder sign)
    logic                res_neg_q, res_neg_d; // product / quotient must be negated
    logic                b_zero_q, b_zero_d;
    logic [WIDTH-1:0]    a_q, a_d;             // |A|, kept for the divide-by-zero remainder
    logic [WIDTH-1:0]    b_q, b_d;             // |B|
    logic [WIDTH-1:0]    hi_q, hi_d;           // partial product high / partial remainder
    logic [WIDTH-1:0]    lo_q, lo_d;           // multiplier bits / dividend-then-quotient bits
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [WIDTH-1:0]    out_hi_q, out_hi_d;
    logic [WIDTH-1:0]    out_lo_q, out_lo_d;
    logic                dbz_q, dbz_d;

    logic                neg_a_in, neg_b_in;
    logic [WIDTH-1:0]    abs_a, abs_b;
    logic [WIDTH:0]      mul_sum;
    logic [WIDTH:0]      div_shift;
    logic                div_ge;
    logic [WIDTH-1:0]    div_sub;
    logic [2*WIDTH-1:0]  prod_fix;
    logic [WIDTH-1:0]    quo_fix, rem_fix, rem_src;
    logic [WIDTH-1:0]    fix_hi, fix_lo;

    assign neg_a_in = (sign == SIGN_SIGNED) && A[WIDTH-1];
    assign neg_b_in = (sign == SIGN_SIGNED) && B[WIDTH-1];

    muldiv_negate #(.WIDTH(WIDTH)) u_abs_a (.en_i(neg_a_in), .val_i(A), .val_o(abs_a));
    muldiv_negate #(.WIDTH(WIDTH)) u_abs_b (.en_i(neg_b_in), .val_i(B), .val_o(abs_b));

    // Shift-add step: add multiplicand when the current multiplier bit is set, shift right.
    assign mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : {WIDTH{1'b0}})};

    // Restoring divide step; when the subtraction succeeds the difference fits WIDTH bits.
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, b_q};
    assign div_sub   = div_shift[WIDTH-1:0] - b_q;

    // With B==0 the remainder is the dividend itself, which also covers the skipped-RUN case.
    assign rem_src = b_zero_q ? a_q : hi_q;

    muldiv_negate #(.WIDTH(2 * WIDTH)) u_neg_prod (
        .en_i (res_neg_q),
        .val_i({hi_q, lo_q}),
        .val_o(prod_fix)
    );
    muldiv_negate #(.WIDTH(WIDTH)) u_neg_quo (.en_i(res_neg_q), .val_i(lo_q), .val_o(quo_fix));
    muldiv_negate #(.WIDTH(WIDTH)) u_neg_rem (.en_i(neg_a_q), .val_i(rem_src), .val_o(rem_fix));

    always_comb begin
        fix_hi = rem_fix;
        fix_lo = b_zero_q ? {WIDTH{1'b1}} : quo_fix;
        if (op_q == OP_MUL) begin
            // A zero multiplier means a zero product even when RUN was skipped.
            {fix_hi, fix_lo} = b_zero_q ? {2 * WIDTH{1'b0}} : prod_fix;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_a_d   = neg_a_q;
        res_neg_d = res_neg_q;
        b_zero_d  = b_zero_q;
        a_d       = a_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        out_hi_d  = out_hi_q;
        out_lo_d  = out_lo_q;
        dbz_d     = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (start && !busy_q) begin
                    a_d       = abs_a;
                    b_d       = abs_b;
                    hi_d      = '0;
                    lo_d      = abs_a;
                    op_d      = op;
                    neg_a_d   = neg_a_in;
                    res_neg_d = neg_a_in ^ neg_b_in;
                    b_zero_d  = (B == '0);
                    cnt_d     = '0;
                    busy_d    = 1'b1;
`ifdef SEQ_MULDIV_EARLY_OUT_EN
                    state_d   = (B == '0) ? FIX : RUN;
`else
                    state_d   = RUN;
`endif
                end
            end
            RUN: begin
                if (op_q == OP_MUL) begin
                    {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
                end else begin
                    hi_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], div_ge};
                end
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end
            end
            FIX: begin
                // First cycle registers the sign-corrected result, second publishes it.
                if (cnt_q == '0) begin
                    hi_d  = fix_hi;
                    lo_d  = fix_lo;
                    cnt_d = CntW'(1);
                end else begin
                    out_hi_d = hi_q;
                    out_lo_d = lo_q;
                    dbz_d    = (op_q == OP_DIV) && b_zero_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= 1'b0;
            neg_a_q   <= 1'b0;
            res_neg_q <= 1'b0;
            b_zero_q  <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            out_hi_q  <= '0;
            out_lo_q  <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_a_q   <= neg_a_d;
            res_neg_q <= res_neg_d;
            b_zero_q  <= b_zero_d;
            a_q       <= a_d;
            b_q       <= b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            out_hi_q  <= out_hi_d;
            out_lo_q  <= out_lo_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign outHI = out_hi_q;
    assign outLO = out_lo_q;
    assign dbz   = dbz_q;

endmodule

// File: tb/tb_seq_muldiv.sv
// tb_seq_muldiv: self-checking bench for seq_muldiv (WIDTH=32).
// Directed vector table, hand-written timing sequences and random operations checked
// against an arithmetic reference model. Honours SEQ_MULDIV_EARLY_OUT_EN if defined.
module tb_seq_muldiv;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op;
    logic [1:0]   sign;
    logic [W-1:0] A, B;
    logic         busy, done, dbz;
    logic [W-1:0] out_hi, out_lo;

    int n_checks = 0;
    int n_fail   = 0;

    seq_muldiv #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .sign (sign),
        .A    (A),
        .B    (B),
        .busy (busy),
        .done (done),
        .outHI(out_hi),
        .outLO(out_lo),
        .dbz  (dbz)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         op;
        logic [1:0]   sg;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
        end
    endtask

    function automatic int exp_latency(input logic [W-1:0] b);
        int early = 0;
`ifdef SEQ_MULDIV_EARLY_OUT_EN
        early = 1;
`endif
        return (early != 0 && b == '0) ? 2 : W + 2;
    endfunction

    // Reference: plain 64-bit arithmetic on the operands as the sign mode interprets them.
    function automatic void model(input logic o, input logic [1:0] sg,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo,
                                  output logic dz);
        longint sa, sb, p, q, r;
        logic   s;
        s  = (sg == 2'b01);
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        dz = 1'b0;
        if (!o) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == '0) begin
            hi = a;
            lo = '1;
            dz = 1'b1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            hi = r[31:0];
            lo = q[31:0];
        end
    endfunction

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    // Called at a negedge. Issues one request, scrambles inputs while busy, optionally
    // pulses start again at iteration poke_at, and returns results at the done cycle.
    task automatic run_op(input logic o, input logic [1:0] sg,
                          input logic [W-1:0] a, input logic [W-1:0] b, input int poke_at,
                          output logic [W-1:0] hi, output logic [W-1:0] lo,
                          output logic dz, output int lat, output int bad_busy);
        logic got;
        start = 1'b1;
        op    = o;
        sign  = sg;
        A     = a;
        B     = b;
        @(posedge clk);
        lat      = -1;
        bad_busy = 0;
        got      = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                lat = i;
                if (busy) bad_busy++;
                start = 1'b0;
            end else begin
                if (!busy) bad_busy++;
                start = (i == poke_at);
                op    = 1'($urandom_range(0, 1));
                sign  = 2'($urandom_range(0, 3));
                A     = W'($urandom);
                B     = W'($urandom);
            end
        end
        hi = out_hi;
        lo = out_lo;
        dz = dbz;
    endtask

    initial begin
        logic [W-1:0] hi, lo, eh, el;
        logic         dz, ed, got;
        int           lat, bad, n_done;

        vecs[0]  = '{1'b0, 2'b00, 32'd7,         32'd6,         32'h0,         32'h2A,        1'b0};
        vecs[1]  = '{1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1,         1'b0};
        vecs[2]  = '{1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1,         1'b0};
        vecs[3]  = '{1'b0, 2'b01, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[4]  = '{1'b0, 2'b11, 32'h8000_0000, 32'd2,         32'h1,         32'h0,         1'b0};
        vecs[5]  = '{1'b1, 2'b01, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[6]  = '{1'b1, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
        vecs[7]  = '{1'b1, 2'b00, 32'd100,       32'd0,         32'h64,        32'hFFFF_FFFF, 1'b1};
        vecs[8]  = '{1'b0, 2'b00, 32'd5,         32'd0,         32'h0,         32'h0,         1'b0};
        vecs[9]  = '{1'b1, 2'b01, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        vecs[10] = '{1'b1, 2'b10, 32'd100,       32'd7,         32'h2,         32'hE,         1'b0};
        vecs[11] = '{1'b1, 2'b01, 32'd7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        sign  = 2'b00;
        A     = '0;
        B     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_dbz", 32'(dbz), 32'd0);
        check("reset_hi", out_hi, 32'd0);
        check("reset_lo", out_lo, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Table: each call starts in the previous done cycle, so back-to-back acceptance
        // is exercised as well.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].sg, vecs[i].a, vecs[i].b, -1, hi, lo, dz, lat, bad);
            check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
            check($sformatf("vec%0d_dbz", i), 32'(dz), 32'(vecs[i].dbz));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_latency(vecs[i].b)));
            check($sformatf("vec%0d_busy", i), 32'(bad), 32'd0);
        end

        // Done lasts one cycle and results hold afterwards and across a new start.
        @(negedge clk);
        check("done_pulse_width", 32'(done), 32'd0);
        check("hold_idle_lo", out_lo, 32'hFFFF_FFFD);
        start = 1'b1;
        op    = 1'b0;
        sign  = 2'b00;
        A     = 32'd3;
        B     = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_busy_hi", out_hi, 32'h1);
        check("hold_busy_lo", out_lo, 32'hFFFF_FFFD);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check("hold_done_seen", 32'(got), 32'd1);
        check("hold_new_lo", out_lo, 32'd9);

        // A start pulsed while busy must be ignored: one done only.
        run_op(1'b0, 2'b00, 32'd12345, 32'd1000, 5, hi, lo, dz, lat, bad);
        check("poke_lo", lo, 32'd12345000);
        check("poke_hi", hi, 32'd0);
        check("poke_latency", 32'(lat), 32'(W + 2));
        n_done = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("poke_extra_done", 32'(n_done), 32'd0);

        run_op(1'b1, 2'b00, 32'd100, 32'd0, -1, hi, lo, dz, lat, bad);
        check("div0_hi", hi, 32'h64);
        check("div0_lo", lo, 32'hFFFF_FFFF);
        check("div0_dbz", 32'(dz), 32'd1);
        check("div0_latency", 32'(lat), 32'(exp_latency(32'd0)));

        // Reset ten edges into a run aborts it and clears the outputs.
        start = 1'b1;
        op    = 1'b0;
        sign  = 2'b00;
        A     = 32'd7;
        B     = 32'd6;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_hi", out_hi, 32'd0);
        check("abort_lo", out_lo, 32'd0);
        check("abort_dbz", 32'(dbz), 32'd0);
        n_done = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);

        run_op(1'b0, 2'b00, 32'd7, 32'd6, -1, hi, lo, dz, lat, bad);
        check("recover_lo", lo, 32'h2A);
        check("recover_latency", 32'(lat), 32'(W + 2));

        for (int k = 0; k < 40; k++) begin
            logic         ro;
            logic [1:0]   rs;
            logic [W-1:0] ra, rb;
            ro = 1'($urandom_range(0, 1));
            rs = 2'($urandom_range(0, 3));
            ra = rand_operand();
            rb = rand_operand();
            model(ro, rs, ra, rb, eh, el, ed);
            run_op(ro, rs, ra, rb, -1, hi, lo, dz, lat, bad);
            check($sformatf("rnd%0d_hi op=%0d s=%0d a=%0h b=%0h", k, ro, rs, ra, rb), hi, eh);
            check($sformatf("rnd%0d_lo op=%0d s=%0d a=%0h b=%0h", k, ro, rs, ra, rb), lo, el);
            check($sformatf("rnd%0d_dbz", k), 32'(dz), 32'(ed));
            check($sformatf("rnd%0d_latency", k), 32'(lat), 32'(exp_latency(rb)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_muldiv.md
Name: seq_muldiv

Overview:
- Multi-cycle multiply/divide responder for the datapath.
- Accepts a single-cycle start request from the control unit and iterates one bit per cycle.
- Returns a 2*WIDTH result split into outHI/outLO (MIPS-style HI/LO) with a one-cycle done pulse.
- Offloads the combinational ALU's mult/div path so the ALU keeps a short critical path.

Parameters:
- WIDTH, 32, operand width; HI/LO each WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request strobe; sampled only when busy=0
- op  input  1  0=multiply, 1=divide
- sign  input  2  2'b01=signed; 2'b00/10/11=unsigned
- A  input  WIDTH  multiplicand / dividend
- B  input  WIDTH  multiplier / divisor
- busy  output  1  high from the cycle after start acceptance until done
- done  output  1  one-cycle pulse; outHI/outLO valid from this cycle
- outHI  output  WIDTH  product[2W-1:W] / remainder
- outLO  output  WIDTH  product[W-1:0] / quotient
- dbz  output  1  divide-by-zero flag for the last completed op

Behaviour:
- Reset: state=IDLE; busy=0, done=0, dbz=0, outHI=0, outLO=0. Reset during RUN/FIX aborts the operation; no done pulse is generated.
- States: IDLE -> RUN on (start & !busy) at edge N.
  - At that edge, latch |A| and |B|. Absolute values are taken only when signed. Also latch the result-sign bits and op.
  - RUN: WIDTH iterations, one per cycle (shift-add for multiply, restoring shift-subtract for divide). 5-bit counter.
  - RUN -> FIX after the last iteration. FIX applies two's-complement negation as required and writes outHI/outLO.
  - FIX -> IDLE with done=1 for exactly one cycle.
- Latency: start sampled at edge N; busy=1 from edges N+1..N+WIDTH+1; done=1 after edge N+WIDTH+2. For WIDTH=32, done appears at cycle N+34.
- While busy, start is ignored and inputs may change freely.
- outHI/outLO/dbz hold their values until the next FIX write. They are not cleared by a new start.
- start during the done cycle is accepted. busy goes high on the next edge.
- Multiply: {outHI,outLO} = A*B.
  - Signed: product is negative iff sign(A)^sign(B).
  - Unsigned: full 2W-bit result, no overflow.
- Divide: outLO = quotient truncated toward zero; outHI = remainder.
  - Remainder takes the sign of the dividend.
- Divide, signed, A=most-negative, B=-1: outLO=A (0x80000000), outHI=0, dbz=0.
- Divide, B=0: outLO=all ones, outHI=A (unmodified), dbz=1. Full latency applies unless the optional feature is enabled.
- dbz=0 for any multiply.

Optional Feature:
- Macro: SEQ_MULDIV_EARLY_OUT_EN.
- Defined: if B==0 at acceptance, skip RUN and go straight to FIX. done then asserts after edge N+2.
  - Divide: results as in the B=0 rule above.
  - Multiply: outHI=outLO=0.
- Undefined: every operation takes the full WIDTH+2 cycle latency regardless of operands.

Decomposition:
- Package muldiv_pkg:
  - op encodings OP_MUL/OP_DIV
  - sign encoding SIGN_SIGNED
  - state enum IDLE/RUN/FIX
  - constant LATENCY = WIDTH+2
- Sub-module muldiv_negate: combinational conditional two's-complement (abs on entry, negate in FIX). It is instantiated for operand and result paths.

Test Plan:
- Unsigned mul A=7, B=6, start at cycle 0 -> done at cycle 34 only; outHI=0, outLO=0x0000002A, dbz=0.
- Unsigned mul A=B=0xFFFFFFFF -> outHI=0xFFFFFFFE, outLO=0x00000001. Same operands signed -> outHI=0, outLO=1.
- Signed mul A=0xFFFFFFFD (-3), B=5 -> outHI=0xFFFFFFFF, outLO=0xFFFFFFF1.
- Signed div A=0xFFFFFFF9 (-7), B=2 -> outLO=0xFFFFFFFD, outHI=0xFFFFFFFF. Signed div 0x80000000 / 0xFFFFFFFF -> outLO=0x80000000, outHI=0.
- Divide A=100, B=0 -> outLO=0xFFFFFFFF, outHI=0x00000064, dbz=1. Done at cycle 34 without the macro, cycle 2 with it.
- Reset asserted at cycle 10 of a run -> next edge busy=0, outputs=0, no done. Second start pulsed at cycle 5 while busy -> ignored; only one done seen.
